// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter between fetch and debug/loader, with debug starvation guard.
// Optional exclusive debug ownership (d_lock, ARB/LOCKED FSM) is built when IMEM_LOCK_EN is defined.
module imem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_req,
    input  logic [ADDRESS_WIDTH-1:0] f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [DATA_WIDTH-1:0]    f_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
`ifdef IMEM_LOCK_EN
    input  logic                     d_lock,
`endif
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_f_vld_p1;
    logic             r_d_vld_p1;
    logic             w_locked;
    logic             w_d_force;
    logic             w_f_gnt;
    logic             w_d_gnt;

`ifdef IMEM_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCKED} state_t;
    state_t r_state;

    // LOCKED is left on the edge where d_lock is sampled low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            case (r_state)
                ST_ARB:    if (w_d_gnt && d_lock) r_state <= ST_LOCKED;
                ST_LOCKED: if (!d_lock)           r_state <= ST_ARB;
                default:                          r_state <= ST_ARB;
            endcase
        end
    end

    assign w_locked = (r_state == ST_LOCKED);
`else
    assign w_locked = 1'b0;
`endif

    // p0: grant decision, fetch wins unless debug has hit the starvation limit
    always_comb begin
        w_d_force = d_req && (r_starve_cnt == LIMIT);
        w_d_gnt   = 1'b0;
        w_f_gnt   = 1'b0;
        if (!rst) begin
            if (w_locked) begin
                w_d_gnt = d_req;
            end else begin
                w_d_gnt = d_req && (!f_req || w_d_force);
                w_f_gnt = f_req && !w_d_gnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_locked || !d_req || w_d_gnt) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= sat_inc(r_starve_cnt);
        end
    end

    // p1: read owner, one cycle behind the grant; writes never return data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_vld_p1 <= 1'b0;
            r_d_vld_p1 <= 1'b0;
        end else begin
            r_f_vld_p1 <= w_f_gnt;
            r_d_vld_p1 <= w_d_gnt && !d_we;
        end
    end

    always_comb begin
        f_gnt     = w_f_gnt;
        d_gnt     = w_d_gnt;
        mem_en    = w_f_gnt || w_d_gnt;
        mem_we    = w_d_gnt && d_we;
        mem_addr  = w_d_gnt ? d_addr : (w_f_gnt ? f_addr : '0);
        mem_wdata = w_d_gnt ? d_wdata : '0;
        f_rvalid  = r_f_vld_p1;
        d_rvalid  = r_d_vld_p1;
        f_rdata   = r_f_vld_p1 ? mem_rdata : '0;
        d_rdata   = r_d_vld_p1 ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, reset/idle sequences and random traffic
// checked against a transaction-level model with its own copy of memory.
module tb_imem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [31:0] f_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef IMEM_LOCK_EN
    logic        d_lock = 1'b0;
`endif

    always #5 clk = ~clk;

    imem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef IMEM_LOCK_EN
        .d_lock(d_lock),
`endif
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Instruction memory attached to the DUT
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Reference model state
    logic [31:0] refmem [256];
    int          m_starve;
    logic        m_fv, m_dv;
    logic [31:0] m_fdata, m_ddata;

    int checks = 0;
    int errors = 0;

    logic        s_fg, s_dg, s_fv, s_dv, s_we;
    logic [31:0] s_frd, s_drd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_fv = 1'b0;
        m_dv = 1'b0;
        m_fdata = '0;
        m_ddata = '0;
    endtask

    task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd);
        logic e_fg, e_dg;
        logic [31:0] e_addr, e_wd, e_frd, e_drd;
        @(negedge clk);
        f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #3;
        e_dg   = dr && (!fr || m_starve == SL);
        e_fg   = fr && !e_dg;
        e_frd  = m_fv ? m_fdata : 32'h0;
        e_drd  = m_dv ? m_ddata : 32'h0;
        e_addr = e_dg ? da : (e_fg ? fa : 32'h0);
        e_wd   = e_dg ? dwd : 32'h0;
        s_fg = f_gnt; s_dg = d_gnt; s_fv = f_rvalid; s_dv = d_rvalid; s_we = mem_we;
        s_frd = f_rdata; s_drd = d_rdata;
        chk("grant", 128'({f_gnt, d_gnt, mem_en, mem_we}),
            128'({e_fg, e_dg, e_fg | e_dg, e_dg & dw}));
        chk("rdata", 128'({f_rvalid, d_rvalid, f_rdata, d_rdata}), 128'({m_fv, m_dv, e_frd, e_drd}));
        chk("mem_bus", 128'({mem_addr, mem_wdata}), 128'({e_addr, e_wd}));
        @(posedge clk);
        m_fv    = e_fg;
        m_fdata = refmem[fa[9:2]];
        m_dv    = e_dg && !dw;
        m_ddata = refmem[da[9:2]];
        if (e_dg && dw) refmem[da[9:2]] = dwd;
        if (e_dg || !dr) m_starve = 0;
        else if (m_starve < SL) m_starve = m_starve + 1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic        fg, dg, fv;
        logic [31:0] frd;
        logic        dv;
        logic [31:0] drd;
        logic        we;
    } vec_t;

    function automatic vec_t mkv(logic fr, logic [31:0] fa, logic dr, logic dw, logic [31:0] da,
                                 logic [31:0] dwd, logic fg, logic dg, logic fv, logic [31:0] frd,
                                 logic dv, logic [31:0] drd, logic we);
        vec_t v;
        v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.fg = fg; v.dg = dg; v.fv = fv; v.frd = frd; v.dv = dv; v.drd = drd; v.we = we;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[14];
        logic        rf, rd, rw, f_hold, d_hold;
        logic [31:0] ra, rda, rwd;

        tbl[0]  = mkv(1, 32'h00, 0, 0, 32'h00, 32'h0,      1, 0, 0, 32'h0,        0, 32'h0,        0);
        tbl[1]  = mkv(1, 32'h04, 0, 0, 32'h00, 32'h0,      1, 0, 1, 32'hC0DE0000, 0, 32'h0,        0);
        tbl[2]  = mkv(1, 32'h08, 0, 0, 32'h00, 32'h0,      1, 0, 1, 32'hC0DE0001, 0, 32'h0,        0);
        tbl[3]  = mkv(0, 32'h00, 0, 0, 32'h00, 32'h0,      0, 0, 1, 32'hC0DE0002, 0, 32'h0,        0);
        tbl[4]  = mkv(0, 32'h00, 1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 0, 32'h0,      0, 32'h0,        1);
        tbl[5]  = mkv(1, 32'h10, 0, 0, 32'h00, 32'h0,      1, 0, 0, 32'h0,        0, 32'h0,        0);
        tbl[6]  = mkv(0, 32'h00, 0, 0, 32'h00, 32'h0,      0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0);
        tbl[7]  = mkv(1, 32'h40, 1, 0, 32'h20, 32'h0,      1, 0, 0, 32'h0,        0, 32'h0,        0);
        tbl[8]  = mkv(1, 32'h40, 1, 0, 32'h20, 32'h0,      1, 0, 1, 32'hC0DE0010, 0, 32'h0,        0);
        tbl[9]  = mkv(1, 32'h40, 1, 0, 32'h20, 32'h0,      1, 0, 1, 32'hC0DE0010, 0, 32'h0,        0);
        tbl[10] = mkv(1, 32'h40, 1, 0, 32'h20, 32'h0,      1, 0, 1, 32'hC0DE0010, 0, 32'h0,        0);
        tbl[11] = mkv(1, 32'h40, 1, 0, 32'h20, 32'h0,      0, 1, 1, 32'hC0DE0010, 0, 32'h0,        0);
        tbl[12] = mkv(1, 32'h40, 0, 0, 32'h00, 32'h0,      1, 0, 0, 32'h0,        1, 32'hC0DE0008, 0);
        tbl[13] = mkv(0, 32'h00, 0, 0, 32'h00, 32'h0,      0, 0, 1, 32'hC0DE0010, 0, 32'h0,        0);

        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hC0DE0000 + 32'(i);
            refmem[i] = 32'hC0DE0000 + 32'(i);
        end

        // Reset held with both requesters active: nothing may be granted
        rst = 1'b1;
        f_req = 1'b1; f_addr = 32'h4; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h1234;
        #12;
        chk("reset_gnt", 128'({f_gnt, d_gnt, mem_en, mem_we, f_rvalid, d_rvalid}), 128'(6'b0));
        chk("reset_data", 128'({f_rdata, d_rdata, mem_addr, mem_wdata}), 128'(0));
        @(negedge clk);
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd);
            chk($sformatf("vec%0d", i),
                128'({s_fg, s_dg, s_fv, s_dv, s_we, s_frd, s_drd}),
                128'({tbl[i].fg, tbl[i].dg, tbl[i].fv, tbl[i].dv, tbl[i].we, tbl[i].frd, tbl[i].drd}));
        end

        // Reset arriving on the same edge as a granted fetch read
        @(negedge clk);
        f_req = 1'b1; f_addr = 32'h8; d_req = 1'b0; d_we = 1'b0;
        #3;
        chk("midread_gnt", 128'(f_gnt), 128'(1));
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("midread_ctl", 128'({f_gnt, d_gnt, mem_en, mem_we, f_rvalid, d_rvalid}), 128'(6'b0));
        chk("midread_data", 128'({f_rdata, d_rdata, mem_addr, mem_wdata}), 128'(0));
        @(negedge clk);
        f_req = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midread_after", 128'({f_rvalid, f_rdata}), 128'(0));

        // Idle stretch, then contention shows the starvation count restarted from zero
        for (int i = 0; i < 10; i++) idle();
        for (int i = 0; i < SL + 2; i++) step(1'b1, 32'h100, 1'b1, 1'b0, 32'h204, 32'h0);
        idle();

`ifdef IMEM_LOCK_EN
        @(negedge clk);
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_lock = 1'b1;
        #3;
        chk("lock_enter", 128'({f_gnt, d_gnt}), 128'(2'b01));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f_req = 1'b1; f_addr = 32'h4; d_req = 1'b1; d_addr = 32'(4 * (i + 1));
            #3;
            chk($sformatf("lock_hold%0d", i), 128'({f_gnt, d_gnt}), 128'(2'b01));
        end
        @(negedge clk);
        d_req = 1'b0; d_lock = 1'b0;
        #3;
        chk("lock_release", 128'({f_gnt, d_gnt}), 128'(2'b00));
        @(negedge clk);
        #3;
        chk("lock_after", 128'({f_gnt, d_gnt}), 128'(2'b10));
        @(negedge clk);
        f_req = 1'b0;
        @(negedge clk);
        model_reset();
`endif

        // Random traffic: requesters hold a request until granted, occasionally dropping it
        f_hold = 1'b0; d_hold = 1'b0;
        rf = 1'b0; rd = 1'b0; rw = 1'b0; ra = '0; rda = '0; rwd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!f_hold || $urandom_range(0, 31) == 0) begin
                rf = ($urandom_range(0, 3) != 0);
                ra = {$urandom} & 32'hFFFF_FFFC;
            end
            if (!d_hold || $urandom_range(0, 31) == 0) begin
                rd  = ($urandom_range(0, 1) != 0);
                rw  = ($urandom_range(0, 2) == 0);
                rda = {$urandom} & 32'hFFFF_FFFC;
                rwd = $urandom;
            end
            step(rf, ra, rd, rw, rda, rwd);
            f_hold = rf && !s_fg;
            d_hold = rd && !s_dg;
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
